// File: rtl/misao_chk_pkg.sv
// Shared types for the misao bus checker: channel FSM states, fail codes and
// the per-channel configuration record.
package misao_chk_pkg;

   localparam int CHK_ADDR_W = 15;
   localparam int CHK_DATA_W = 16;
   localparam int CHK_DLY_W  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      COUNT = 2'd2,
      DONE  = 2'd3
   } chk_state_e;

   typedef enum logic [1:0] {
      NONE    = 2'd0,
      RDATA   = 2'd1,
      ACC     = 2'd2,
      TIMEOUT = 2'd3
   } chk_code_e;

   typedef struct packed {
      logic [CHK_ADDR_W-1:0] addr;
      logic                  rd_en;
      logic [7:0]            rd_exp;
      logic [CHK_DLY_W-1:0]  delay;
      logic [CHK_DATA_W-1:0] exp_data;
      logic                  exp_carry;
   } chk_cfg_t;

endpackage

// File: rtl/misao_chk_channel.sv
// One check slot: config register, IDLE/ARMED/COUNT/DONE FSM and the
// post-trigger delay counter. The current state is exported for observation.
module misao_chk_channel
   import misao_chk_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cfg_load,
   input  chk_cfg_t              cfg_in,
   input  logic                  start,
   input  logic                  timeout,
   input  logic                  mem_enable_read,
   input  logic [CHK_ADDR_W-1:0] mem_addr,
   input  logic [7:0]            mem_data_in,
   input  logic [CHK_DATA_W-1:0] test_data,
   input  logic                  test_carry,
   output chk_state_e            state,
   output logic                  configured,
   output logic                  done,
   output logic                  pass,
   output chk_code_e             code
);

   chk_cfg_t             cfg_q;
   logic [CHK_DLY_W-1:0] dly_cnt;
   logic                 trig;
   logic                 rd_ok;
   logic                 acc_ok;

   assign trig   = mem_enable_read && (mem_addr == cfg_q.addr);
   assign rd_ok  = !cfg_q.rd_en || (mem_data_in == cfg_q.rd_exp);
   assign acc_ok = (test_data == cfg_q.exp_data) && (test_carry == cfg_q.exp_carry);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         configured <= 1'b0;
         cfg_q      <= '0;
         dly_cnt    <= '0;
         done       <= 1'b0;
         pass       <= 1'b0;
         code       <= NONE;
      end else begin
         case (state)
            IDLE, DONE: begin
               // A config write on the same edge as start wins; the slot stays IDLE.
               if (cfg_load) begin
                  cfg_q      <= cfg_in;
                  configured <= 1'b1;
                  state      <= IDLE;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  code       <= NONE;
               end else if (start && configured) begin
                  state <= ARMED;
                  done  <= 1'b0;
                  pass  <= 1'b0;
                  code  <= NONE;
               end
            end
            ARMED: begin
               if (trig) begin
                  if (!rd_ok) begin
                     state <= DONE;
                     done  <= 1'b1;
                     code  <= RDATA;
                  end else if (cfg_q.delay == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                     pass  <= acc_ok;
                     code  <= acc_ok ? NONE : ACC;
                  end else begin
                     dly_cnt <= cfg_q.delay;
                     state   <= COUNT;
                  end
               end else if (timeout) begin
                  state <= DONE;
                  done  <= 1'b1;
                  code  <= TIMEOUT;
               end
            end
            COUNT: begin
               // A compare falling on the timeout edge takes precedence over the timeout.
               if (dly_cnt == CHK_DLY_W'(1)) begin
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= acc_ok;
                  code  <= acc_ok ? NONE : ACC;
               end else if (timeout) begin
                  state <= DONE;
                  done  <= 1'b1;
                  code  <= TIMEOUT;
               end else begin
                  dly_cnt <= dly_cnt - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/misao_bus_checker.sv
// Snoops the misao read bus and ACC/carry debug outputs with CHANNELS
// independent check slots sharing one saturating timeout counter.
module misao_bus_checker
   import misao_chk_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = CHK_ADDR_W,
   parameter int DATA_W   = CHK_DATA_W,
   parameter int DLY_W    = CHK_DLY_W,
   parameter int TO_W     = 8,
   localparam int IDX_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  mem_enable_read,
   input  logic [ADDR_W-1:0]     mem_addr,
   input  logic [7:0]            mem_data_in,
   input  logic [DATA_W-1:0]     test_data,
   input  logic                  test_carry,
   input  logic                  cfg_we,
   input  logic [IDX_W-1:0]      cfg_idx,
   input  logic [ADDR_W-1:0]     cfg_addr,
   input  logic                  cfg_rd_en,
   input  logic [7:0]            cfg_rd_exp,
   input  logic [DLY_W-1:0]      cfg_delay,
   input  logic [DATA_W-1:0]     cfg_exp_data,
   input  logic                  cfg_exp_carry,
   input  logic                  start,
   output logic [CHANNELS-1:0]   ch_done,
   output logic [CHANNELS-1:0]   ch_pass,
   output logic [2*CHANNELS-1:0] ch_code,
   output logic                  all_done,
   output logic                  any_fail,
   output logic                  busy
);

   localparam logic [TO_W-1:0] TO_MAX = '1;

   chk_cfg_t            cfg_word;
   logic [CHANNELS-1:0] cfg_load;
   logic [CHANNELS-1:0] active;
   logic [CHANNELS-1:0] configured;
   logic [TO_W-1:0]     to_cnt;
   logic                timeout;

   // The struct widths come from the package; the port widths must match them.
   assign cfg_word = '{addr: cfg_addr, rd_en: cfg_rd_en, rd_exp: cfg_rd_exp,
                       delay: cfg_delay, exp_data: cfg_exp_data,
                       exp_carry: cfg_exp_carry};

   assign busy    = |active;
   assign timeout = busy && (to_cnt == TO_MAX - 1'b1);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      chk_state_e state;
      chk_code_e  code;

      assign cfg_load[g]       = cfg_we && (cfg_idx == IDX_W'(g));
      assign ch_code[2*g +: 2] = code;
      assign active[g]         = (state == ARMED) || (state == COUNT);

      misao_chk_channel u_ch (
         .clk             (clk),
         .rst             (rst),
         .cfg_load        (cfg_load[g]),
         .cfg_in          (cfg_word),
         .start           (start),
         .timeout         (timeout),
         .mem_enable_read (mem_enable_read),
         .mem_addr        (mem_addr),
         .mem_data_in     (mem_data_in),
         .test_data       (test_data),
         .test_carry      (test_carry),
         .state           (state),
         .configured      (configured[g]),
         .done            (ch_done[g]),
         .pass            (ch_pass[g]),
         .code            (code)
      );
   end

   // Counts only while a check is outstanding and sticks at its maximum.
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt <= '0;
      end else if (start) begin
         to_cnt <= '0;
      end else if (busy && (to_cnt != TO_MAX)) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         all_done <= 1'b0;
         any_fail <= 1'b0;
      end else begin
         all_done <= (|configured) && (&(ch_done | ~configured));
         any_fail <= |(ch_done & ~ch_pass);
      end
   end

endmodule
